// File: rtl/rf_wport_arb_if.sv
// Register-file write-port arbiter bus: WB request, LU result stream, RF write triple,
// pending-destination mask and performance counters.
interface rf_wport_arb_if #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5
);
  logic                    wb_wr_reg;
  logic [REGNOBITS-1:0]    wb_wregno;
  logic [DBITS-1:0]        wb_regval;
  logic                    stall_wb;
  logic                    lu_valid;
  logic                    lu_ready;
  logic [REGNOBITS-1:0]    lu_wregno;
  logic [DBITS-1:0]        lu_regval;
  logic                    rf_we;
  logic [REGNOBITS-1:0]    rf_wregno;
  logic [DBITS-1:0]        rf_wdata;
  logic [2**REGNOBITS-1:0] pend_mask;
  logic [31:0]             cnt_confl;
  logic [31:0]             cnt_force;

  modport master (
    output wb_wr_reg, wb_wregno, wb_regval, lu_valid, lu_wregno, lu_regval,
    input  stall_wb, lu_ready, rf_we, rf_wregno, rf_wdata, pend_mask, cnt_confl, cnt_force
  );

  modport slave (
    input  wb_wr_reg, wb_wregno, wb_regval, lu_valid, lu_wregno, lu_regval,
    output stall_wb, lu_ready, rf_we, rf_wregno, rf_wdata, pend_mask, cnt_confl, cnt_force
  );
endinterface

// File: rtl/rf_wport_arb.sv
// Single RF write-port arbiter: WB has priority, LU results buffer in a FIFO with a starvation guard.
// Optional perf counters (cnt_confl, cnt_force) enabled by defining RF_ARB_PERF_CNT_EN.
module rf_wport_arb #(
  parameter int DBITS      = 32,
  parameter int REGNOBITS  = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  rf_wport_arb_if.slave bus
);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int SCW  = $clog2(STARVE_MAX + 1);
  localparam int NREG = 2 ** REGNOBITS;

  typedef enum logic [0:0] {
    WB_PRI   = 1'b0,
    LU_FORCE = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [SCW-1:0]       starve_r, starve_s;
  logic [REGNOBITS-1:0] mem_regno_r [FIFO_DEPTH];
  logic [DBITS-1:0]     mem_data_r  [FIFO_DEPTH];
  logic [PTRW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CNTW-1:0]      count_r;
  logic                 empty_s, full_s, lu_ready_s, push_s, pop_s, grant_wb_s;
  logic [REGNOBITS-1:0] sel_regno_s;
  logic [DBITS-1:0]     sel_data_s;
  logic [NREG-1:0]      mask_s;
  logic                 rf_we_r;
  logic [REGNOBITS-1:0] rf_wregno_r;
  logic [DBITS-1:0]     rf_wdata_r;

  assign empty_s    = (count_r == CNTW'(0));
  assign full_s     = (count_r == CNTW'(FIFO_DEPTH));
  // Readiness looks only at occupancy, never at a same-cycle pop.
  assign lu_ready_s = reset && !full_s;
  assign push_s     = bus.lu_valid && lu_ready_s;

  // Arbitration and starvation-guard next-state logic.
  always_comb begin
    state_s    = state_r;
    starve_s   = starve_r;
    grant_wb_s = 1'b0;
    pop_s      = 1'b0;
    case (state_r)
      WB_PRI: begin
        if (bus.wb_wr_reg) begin
          grant_wb_s = 1'b1;
          if (!empty_s) begin
            starve_s = starve_r + SCW'(1);
            if (starve_s == SCW'(STARVE_MAX)) begin
              state_s = LU_FORCE;
            end else begin
              state_s = WB_PRI;
            end
          end else begin
            starve_s = '0;
          end
        end else if (!empty_s) begin
          pop_s    = 1'b1;
          starve_s = '0;
        end else begin
          starve_s = '0;
        end
      end
      LU_FORCE: begin
        pop_s    = 1'b1;
        starve_s = '0;
        state_s  = WB_PRI;
      end
      default: begin
        state_s  = WB_PRI;
        starve_s = '0;
      end
    endcase
    if (grant_wb_s) begin
      sel_regno_s = bus.wb_wregno;
      sel_data_s  = bus.wb_regval;
    end else begin
      sel_regno_s = mem_regno_r[rd_ptr_r];
      sel_data_s  = mem_data_r[rd_ptr_r];
    end
  end

  // FSM state and starvation counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= WB_PRI;
      starve_r <= '0;
    end else begin
      state_r  <= state_s;
      starve_r <= starve_s;
    end
  end

  // LU result FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_regno_r[wr_ptr_r] <= bus.lu_wregno;
        mem_data_r[wr_ptr_r]  <= bus.lu_regval;
        wr_ptr_r              <= wr_ptr_r + PTRW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTRW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered write triple; x0 grants consume the slot but never write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we_r     <= 1'b0;
      rf_wregno_r <= '0;
      rf_wdata_r  <= '0;
    end else if (grant_wb_s || pop_s) begin
      rf_we_r     <= (sel_regno_s != '0);
      rf_wregno_r <= sel_regno_s;
      rf_wdata_r  <= sel_data_s;
    end else begin
      rf_we_r     <= 1'b0;
    end
  end

  // Pending-destination mask over the valid FIFO window starting at the head.
  always_comb begin
    mask_s = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (CNTW'(k) < count_r) begin
        mask_s[mem_regno_r[rd_ptr_r + PTRW'(k)]] = 1'b1;
      end else begin
        mask_s = mask_s;
      end
    end
    mask_s[0] = 1'b0;
  end

  assign bus.stall_wb  = (state_r == LU_FORCE);
  assign bus.lu_ready  = lu_ready_s;
  assign bus.pend_mask = reset ? mask_s : '0;
  assign bus.rf_we     = rf_we_r;
  assign bus.rf_wregno = rf_wregno_r;
  assign bus.rf_wdata  = rf_wdata_r;

`ifdef RF_ARB_PERF_CNT_EN
  logic [31:0] cnt_confl_r, cnt_force_r;

  // Conflict and forced-grant performance counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_confl_r <= 32'd0;
      cnt_force_r <= 32'd0;
    end else begin
      if (state_r == WB_PRI && bus.wb_wr_reg && !empty_s) begin
        cnt_confl_r <= cnt_confl_r + 32'd1;
      end
      if (state_r == LU_FORCE) begin
        cnt_force_r <= cnt_force_r + 32'd1;
      end
    end
  end

  assign bus.cnt_confl = cnt_confl_r;
  assign bus.cnt_force = cnt_force_r;
`else
  assign bus.cnt_confl = 32'd0;
  assign bus.cnt_force = 32'd0;
`endif
endmodule
